// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, issues in-order memory requests, buffers returned
// words in a small FIFO and drives the IF/ID register toward decode.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int unsigned     PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned     CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(BUF_DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]  pcf_q, pcf_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  fifo_pc_q    [BUF_DEPTH];
    logic [XLEN-1:0]  fifo_instr_q [BUF_DEPTH];

    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic             valid_q, valid_d;

    logic             pop, push, rsp_live, accept;
    logic [CNT_W:0]   occ;
    logic [CNT_W-1:0] live;
    logic [XLEN-1:0]  rsp_pc;

    // Request side. A slot freed by this cycle's pop counts as free, which keeps a
    // 1-cycle memory streaming one instruction per cycle.
    always_comb begin
        pop            = !FlushD && !StallD && (cnt_q != '0);
        rsp_live       = imem_rsp_valid && (drop_q == '0);
        push           = rsp_live && !PCSrcE;
        occ            = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(out_q) - (CNT_W+1)'(pop);
        imem_req_valid = rst_n && !PCSrcE && (occ < DEPTH_C) && (!StallF || pend_q);
        imem_req_addr  = pcf_q;
        accept         = imem_req_valid && imem_req_ready;
        // Live requests have consecutive PCs ending at PCF-4, so the oldest one's PC
        // is recovered from the live count instead of being stored.
        live           = out_q - drop_q;
        rsp_pc         = pcf_q - (XLEN'(live) << 2);
    end

    always_comb begin
        pcf_d    = pcf_q;
        pend_d   = imem_req_valid && !imem_req_ready;
        out_d    = out_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (PCSrcE) begin
            pcf_d    = PCTargetE;
            drop_d   = out_q - CNT_W'(imem_rsp_valid);
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept) pcf_d = pcf_q + XLEN'(4);
            drop_d   = drop_q - CNT_W'(imem_rsp_valid && (drop_q != '0));
            cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (FlushD || (!StallD && !pop)) begin
            instr_d = NOP;
            pc_d    = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (pop) begin
            instr_d = fifo_instr_q[rd_ptr_q];
            pc_d    = fifo_pc_q[rd_ptr_q];
            pc4_d   = fifo_pc_q[rd_ptr_q] + XLEN'(4);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q    <= RESET_PC;
            pend_q   <= 1'b0;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            instr_q  <= NOP;
            pc_q     <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            assert (!(push && !pop && ({1'b0, cnt_q} == DEPTH_C)));
            pcf_q    <= pcf_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= rsp_pc;
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with random latency/backpressure and a
// program-order reference of the instruction stream seen by decode.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    logic [31:0] mem_addr [$];
    int          mem_due  [$];
    int          last_due, cyc, lat_min, lat_max;
    logic [31:0] m_pcf, exp_next;
    logic        prev_req, prev_rdy, last_rv;
    logic [31:0] prev_addr;
    logic        pV;
    logic [31:0] pI, pP, pP4;
    int          n_deliv, first_deliv_cyc;
    logic        cap_redirect, got_after, seen_wrap;
    logic [31:0] first_pc_after, wrap_p4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        mem_addr.delete(); mem_due.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_validd", ValidD, 0);
        chk("rst_instrd", InstrD, NOP);
        chk("rst_pcd", PCD, 0);
        chk("rst_pcplus4d", PCPlus4D, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        rst_n = 1'b1;
        m_pcf = 32'h0; exp_next = 32'h0; cyc = 1; last_due = 0;
        prev_req = 0; prev_rdy = 0; prev_addr = '0; last_rv = 0;
        pV = 0; pI = NOP; pP = 0; pP4 = 0;
        n_deliv = 0; first_deliv_cyc = 0;
        cap_redirect = 0; got_after = 0; seen_wrap = 0;
    endtask

    // One clock cycle: memory response, request-side checks, edge, model update, decode checks.
    task automatic step();
        logic        rv, rdy, pend;
        logic [31:0] ra;
        int          due;
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #2;
        rv = imem_req_valid; ra = imem_req_addr; rdy = imem_req_ready;
        pend = prev_req && !prev_rdy;
        if (PCSrcE) chk("req_retract", rv, 0);
        else if (pend) begin
            chk("req_hold_valid", rv, 1);
            chk("req_hold_addr", ra, prev_addr);
        end else if (StallF) chk("req_stallf", rv, 0);
        if (rv) chk("req_addr", ra, m_pcf);
        chk("inflight_bound", 32'(mem_addr.size() <= DEPTH), 1);
        @(posedge clk);
        #1;
        if (imem_rsp_valid) begin
            mem_addr.delete(0);
            mem_due.delete(0);
        end
        if (rv && rdy) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            mem_addr.push_back(ra);
            mem_due.push_back(due);
            last_due = due;
        end
        if (PCSrcE) m_pcf = PCTargetE;
        else if (rv && rdy) m_pcf = m_pcf + 32'd4;
        if (FlushD) begin
            chk("flush_validd", ValidD, 0);
            chk("flush_instrd", InstrD, NOP);
            chk("flush_pcd", PCD, 0);
            chk("flush_pcplus4d", PCPlus4D, 0);
        end else if (StallD) begin
            chk("hold_validd", ValidD, pV);
            chk("hold_instrd", InstrD, pI);
            chk("hold_pcd", PCD, pP);
            chk("hold_pcplus4d", PCPlus4D, pP4);
        end else if (ValidD) begin
            chk("pcd", PCD, exp_next);
            chk("instrd", InstrD, instr_of(exp_next));
            chk("pcplus4d", PCPlus4D, exp_next + 32'd4);
            if (cap_redirect) begin first_pc_after = PCD; cap_redirect = 0; got_after = 1; end
            if (PCD == 32'hFFFF_FFFC) begin seen_wrap = 1; wrap_p4 = PCPlus4D; end
            if (first_deliv_cyc == 0) first_deliv_cyc = cyc;
            n_deliv++;
            exp_next = exp_next + 32'd4;
        end else begin
            chk("bubble_instrd", InstrD, NOP);
        end
        if (PCSrcE) begin exp_next = PCTargetE; cap_redirect = 1; got_after = 0; end
        pV = ValidD; pI = InstrD; pP = PCD; pP4 = PCPlus4D;
        prev_req = rv; prev_rdy = rdy; prev_addr = ra; last_rv = rv;
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic sf, input logic sd);
        PCSrcE = 1; FlushD = 1; PCTargetE = tgt; StallF = sf; StallD = sd;
        step();
        PCSrcE = 0; FlushD = 0; StallF = 0; StallD = 0;
    endtask

    initial begin
        logic [31:0] tmp;
        int          base;
        lat_min = 1; lat_max = 1;
        do_reset();

        // Streaming from reset with a 1-cycle memory
        imem_req_ready = 1;
        repeat (5) step();
        chk("t1_first_valid_cycle", 32'(first_deliv_cyc), 3);
        chk("t1_back_to_back", 32'(n_deliv), 3);
        repeat (3) step();

        // Reset mid-stream, then ready low for 5 cycles
        do_reset();
        imem_req_ready = 0;
        repeat (5) step();
        chk("t2_req_valid", imem_req_valid, 1);
        chk("t2_req_addr", imem_req_addr, 0);
        chk("t2_validd", ValidD, 0);

        // Decode stall with the buffer full
        imem_req_ready = 1;
        repeat (6) step();
        StallD = 1;
        step();
        step();
        chk("t3_noreq_2", last_rv, 0);
        step();
        chk("t3_noreq_3", last_rv, 0);
        StallD = 0;
        base = n_deliv;
        repeat (6) step();
        chk("t3_resumed", 32'(n_deliv > base), 1);

        // Redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mem_addr.size() != 2; i++) step();
        chk("t4_two_outstanding", 32'(mem_addr.size()), 2);
        redirect(32'h0000_0100, 0, 0);
        repeat (15) step();
        chk("t4_delivered", got_after, 1);
        chk("t4_first_pc", first_pc_after, 32'h0000_0100);

        // Redirect together with StallF and StallD
        lat_min = 1; lat_max = 1;
        redirect(32'h0000_0200, 1, 1);
        chk("t5_validd", ValidD, 0);
        repeat (8) step();
        chk("t5_first_pc", first_pc_after, 32'h0000_0200);

        // PC wrap-around
        redirect(32'hFFFF_FFF8, 0, 0);
        repeat (10) step();
        chk("t6_seen_wrap", seen_wrap, 1);
        chk("t6_wrap_pcplus4", wrap_p4, 32'h0);

        // Randomised traffic, with a reset in the middle
        lat_min = 1; lat_max = 4;
        for (int half = 0; half < 2; half++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                imem_req_ready = ($urandom_range(99) < 75);
                StallF = ($urandom_range(99) < 20);
                StallD = ($urandom_range(99) < 20);
                PCSrcE = ($urandom_range(99) < 4);
                FlushD = PCSrcE;
                tmp = $urandom;
                PCTargetE = tmp & 32'hFFFF_FFFC;
                step();
            end
            PCSrcE = 0; FlushD = 0;
            chk("rand_progress", 32'(n_deliv >= 100), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
